reg_file_scrub: RTL
===================

Name: reg_file_scrub

Overview:
- Parametrised integer register file for the single-cycle core: 2 combinational read ports, 1 synchronous write port.
- Adds a hardwired-zero register, optional write-to-read bypass, and a clear sequencer (FSM).
- The sequencer zeroes every register after reset and on request, holding `ready` low while it runs.
- Sits between the decoder (A1/A2/A3) and the ALU/writeback mux. Replaces the fixed 32x32 register file.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers (power of 2, ≥2).
- AW, 5, address width, equal to log2(NREGS).
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- A1  in  AW  read address, port 1.
- A2  in  AW  read address, port 2.
- A3  in  AW  write address.
- WD3  in  XLEN  write data.
- WE3  in  1  write enable.
- clr_req  in  1  request a full clear (single-cycle pulse or level).
- RD1  out  XLEN  read data, port 1.
- RD2  out  XLEN  read data, port 2.
- ready  out  1  register file usable; writes accepted, reads valid.
- clear_done  out  1  one-cycle pulse when a clear sweep finishes.
- wr_drop  out  1  combinational; WE3 asserted but the write was discarded.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- FSM has 2 states: CLEAR and IDLE. A sweep index idx (AW bits) advances through the array.
- rst asserted:
  - state=CLEAR, idx=0, ready=0, clear_done=0, immediately and asynchronously.
  - The storage array itself is not reset.
- CLEAR state:
  - Each rising edge writes 0 to register[idx] and increments idx.
  - On the edge where idx==NREGS-1: that register is written, state goes to IDLE, and clear_done=1 for the following cycle only.
  - After rst deasserts, a sweep takes exactly NREGS edges; ready=1 after the NREGS-th edge.
  - clr_req is ignored in CLEAR; a running sweep is not restarted.
  - rst asserted mid-sweep restarts the sweep at idx=0.
- IDLE state:
  - ready=1.
  - clr_req=1 at an edge: state goes to CLEAR with idx=0, and ready=0 from the next cycle.
  - clr_req has priority over a same-cycle write. That write is not performed and wr_drop=1.
- Writes:
  - Performed at a rising edge only when WE3=1 and ready=1 and clr_req=0.
  - Also require A3≠0 if ZERO_REG=1.
  - A write to register 0 with ZERO_REG=1 is silently ignored; wr_drop=0.
- wr_drop = WE3 & (~ready | clr_req).
- Reads (combinational):
  - RD1/RD2 = 0 when ready=0, including during reset.
  - RD1/RD2 = 0 when the address is 0 and ZERO_REG=1.
  - RD1/RD2 = WD3 if BYPASS=1 and a write to the same address is being performed this cycle.
  - Otherwise RD1/RD2 = register[addr].
  - A1==A2 is legal; both ports return identical data.
- clear_done resets to 0 and is high for exactly one cycle per completed sweep.
- No undefined reads after the first sweep: every location is written before ready rises.

Test Plan:
- Reset sweep: pulse rst, release, and count edges until ready=1.
  - Required: exactly 32 edges and one clear_done pulse.
  - RD1/RD2=0 throughout; afterwards every address reads 0.
- Write/read with BYPASS=1:
  - Write A3=9, WD3=0x00000020, with A1=9 in the same cycle → RD1=0x00000020 combinationally.
  - Next cycle, A2=9 → RD2=0x00000020.
- Hardwired zero: WE3=1, A3=0, WD3=0xDEADBEEF → RD1(A1=0)=0 next cycle, wr_drop=0.
- Clear request:
  - Load regs 6=0x40 and 9=0x20, then pulse clr_req with a same-cycle write A3=6, WD3=0x99.
  - Required: wr_drop=1, ready low for 32 cycles, then reg6=reg9=0 and clear_done pulses once.
- Write during sweep: WE3=1, A3=3, WD3=0x1234 at idx=10 → wr_drop=1; after ready, reg3=0.
- Reset mid-sweep:
  - Assert rst at idx=20 → ready=0 immediately.
  - After release, ready rises exactly 32 edges later with one clear_done pulse; no pulse from the aborted sweep.

Source files
------------

// File: rtl/reg_file_scrub.sv
// Integer register file with two combinational read ports and one write port.
// Includes a hardwired-zero register, write-to-read bypass and a clear sweep.
module reg_file_scrub #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic            WE3,
    input  logic            clr_req,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            ready,
    output logic            clear_done,
    output logic            wr_drop
);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   idx_reg, idx_next;
    logic            clear_done_reg, clear_done_next;
    logic            write_en;
    logic [XLEN-1:0] mem [NREGS];

    logic [AW-1:0]   raddr [2];
    logic [XLEN-1:0] rdata [2];

    assign ready      = (state_reg == IDLE);
    assign clear_done = clear_done_reg;
    assign wr_drop    = WE3 & (~ready | clr_req);

    // A pending clear outranks a same-cycle write; register 0 may be write-protected.
    assign write_en = WE3 & ready & ~clr_req & (!ZERO_REG || (A3 != '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= CLEAR;
            idx_reg        <= '0;
            clear_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            clear_done_reg <= clear_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        clear_done_next = 1'b0;
        case (state_reg)
            CLEAR: begin
                idx_next = idx_reg + 1'b1;
                if (idx_reg == AW'(NREGS - 1)) begin
                    state_next      = IDLE;
                    clear_done_next = 1'b1;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                idx_next   = '0;
            end
        endcase
    end

    // Storage carries no reset; the sweep writes every location before ready rises.
    always_ff @(posedge clk) begin
        if (state_reg == CLEAR) begin
            mem[idx_reg] <= '0;
        end else if (write_en) begin
            mem[A3] <= WD3;
        end
    end

    assign raddr[0] = A1;
    assign raddr[1] = A2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                if (!ready) begin
                    rdata[gi] = '0;
                end else if (ZERO_REG && (raddr[gi] == '0)) begin
                    rdata[gi] = '0;
                end else if (BYPASS && write_en && (A3 == raddr[gi])) begin
                    rdata[gi] = WD3;
                end else begin
                    rdata[gi] = mem[raddr[gi]];
                end
            end
        end
    endgenerate

    assign RD1 = rdata[0];
    assign RD2 = rdata[1];

endmodule
